bp_update_sched: RTL

//  Schedules branch-predictor maintenance for the dual-issue core. After reset it sweeps

---
 rtl/bp_update_sched_if.sv | 43 ++++
 rtl/bp_update_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bp_update_sched_if.sv
// Resolution-lane and table-update bundle for bp_update_sched.
// The slave modport is the scheduler side and the master modport is the core/table side.
`timescale 1ns/1ps
interface bp_update_sched_if #(
    parameter int ABITS = 10
);
    logic              res0_valid_i;
    logic [31:0]       res0_pc_i;
    logic              res0_taken_i;
    logic [31:0]       res0_target_i;
    logic              res1_valid_i;
    logic [31:0]       res1_pc_i;
    logic              res1_taken_i;
    logic [31:0]       res1_target_i;
    logic              ready_o;
    logic              upd_valid_o;
    logic [31:0]       upd_pc_o;
    logic              upd_taken_o;
    logic [31:0]       upd_target_o;
    logic              pht_upd_o;
    logic              btb_upd_o;
    logic              init_we_o;
    logic [ABITS-1:0]  init_idx_o;
    logic              fetch_stall_o;
    logic [15:0]       drop_cnt_o;
    logic [31:0]       upd_cnt_o;

    modport slave (
        input  res0_valid_i, res0_pc_i, res0_taken_i, res0_target_i,
        input  res1_valid_i, res1_pc_i, res1_taken_i, res1_target_i,
        output ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_target_o,
        output pht_upd_o, btb_upd_o, init_we_o, init_idx_o, fetch_stall_o,
        output drop_cnt_o, upd_cnt_o
    );

    modport master (
        output res0_valid_i, res0_pc_i, res0_taken_i, res0_target_i,
        output res1_valid_i, res1_pc_i, res1_taken_i, res1_target_i,
        input  ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_target_o,
        input  pht_upd_o, btb_upd_o, init_we_o, init_idx_o, fetch_stall_o,
        input  drop_cnt_o, upd_cnt_o
    );
endinterface

// File: rtl/bp_update_sched.sv
// Branch-predictor maintenance scheduler: post-reset PHT/BTB clear sweep, then an in-order
// resolution FIFO drained one entry per cycle. Define BP_SCHED_STATS_EN to build drop/update counters.
`timescale 1ns/1ps
module bp_update_sched #(
    parameter int ABITS = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    bp_update_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           r_state;
    logic [ABITS-1:0] r_init_idx;
    logic             r_init_we;
    logic             r_fetch_stall;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [31:0]      r_pc_mem    [DEPTH];
    logic             r_taken_mem [DEPTH];
    logic [31:0]      r_tgt_mem   [DEPTH];

    logic             w_run;
    logic             w_ready;
    logic             w_empty;
    logic             w_pop;
    logic             w_enq0;
    logic             w_enq1;
    logic [1:0]       w_enq_n;
    logic [PW-1:0]    w_wr_ptr1;

    assign w_run     = (r_state == ST_RUN);
    assign w_ready   = w_run && (r_count <= READY_MAX);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty;
    // Acceptance is all-or-nothing per cycle: ready guarantees room for both lanes.
    assign w_enq0    = w_ready && bus.res0_valid_i;
    assign w_enq1    = w_ready && bus.res1_valid_i;
    assign w_enq_n   = {1'b0, w_enq0} + {1'b0, w_enq1};
    assign w_wr_ptr1 = r_wr_ptr + PW'(w_enq0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state       <= ST_INIT;
            r_init_idx    <= '0;
            r_init_we     <= 1'b1;
            r_fetch_stall <= 1'b1;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_idx == '1) begin
                        r_state       <= ST_RUN;
                        r_init_idx    <= '0;
                        r_init_we     <= 1'b0;
                        r_fetch_stall <= 1'b0;
                    end else begin
                        r_init_idx <= r_init_idx + ABITS'(1);
                    end
                end
                ST_RUN: begin
                    r_wr_ptr <= r_wr_ptr + PW'(w_enq_n);
                    r_rd_ptr <= r_rd_ptr + PW'(w_pop);
                    r_count  <= r_count + (PW+1)'(w_enq_n) - (PW+1)'(w_pop);
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_enq0) begin
            r_pc_mem[r_wr_ptr]    <= bus.res0_pc_i;
            r_taken_mem[r_wr_ptr] <= bus.res0_taken_i;
            r_tgt_mem[r_wr_ptr]   <= bus.res0_target_i;
        end
        if (w_enq1) begin
            r_pc_mem[w_wr_ptr1]    <= bus.res1_pc_i;
            r_taken_mem[w_wr_ptr1] <= bus.res1_taken_i;
            r_tgt_mem[w_wr_ptr1]   <= bus.res1_target_i;
        end
    end

    // Head fields are forced to zero when empty so stale storage never reaches the tables.
    assign bus.ready_o       = w_ready;
    assign bus.upd_valid_o   = !w_empty;
    assign bus.upd_pc_o      = w_empty ? 32'd0 : r_pc_mem[r_rd_ptr];
    assign bus.upd_taken_o   = !w_empty && r_taken_mem[r_rd_ptr];
    assign bus.upd_target_o  = w_empty ? 32'd0 : r_tgt_mem[r_rd_ptr];
    assign bus.pht_upd_o     = !w_empty;
    assign bus.btb_upd_o     = !w_empty && r_taken_mem[r_rd_ptr];
    assign bus.init_we_o     = r_init_we;
    assign bus.init_idx_o    = r_init_idx;
    assign bus.fetch_stall_o = r_fetch_stall;

`ifdef BP_SCHED_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [31:0] r_upd_cnt;
    logic [1:0]  w_drop_n;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_drop_n = {1'b0, bus.res0_valid_i && !w_ready} + {1'b0, bus.res1_valid_i && !w_ready};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_drop_cnt <= '0;
            r_upd_cnt  <= '0;
        end else begin
            r_drop_cnt <= sat_add16(r_drop_cnt, w_drop_n);
            r_upd_cnt  <= r_upd_cnt + 32'(w_pop);
        end
    end

    assign bus.drop_cnt_o = r_drop_cnt;
    assign bus.upd_cnt_o  = r_upd_cnt;
`else
    assign bus.drop_cnt_o = 16'd0;
    assign bus.upd_cnt_o  = 32'd0;
`endif
endmodule
